machine_ctl: RTL and testbench
==============================

Name: machine_ctl

Overview:
- Instruction-sequencing controller of the simple CPU. It is the consumer of the fetch strobe that the clock generator drives.
- Waits idle until fetch is first seen high, then runs a free-running 8-step machine cycle.
- In each step it drives the datapath strobes (inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt) from the current step, the opcode and the accumulator zero flag.
- Sits between clk_gen/instruction register and the PC, accumulator, bus and RAM.

Parameters:
HALT_STICKY, 1, 1: HLT parks the controller in HALTED until reset; 0: halt is a one-cycle pulse and the cycle continues.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
fetch  input  1  fetch-window strobe from clk_gen (changes on negedge clk)
opcode  input  3  instruction register opcode field
zero  input  1  accumulator-is-zero flag
inc_pc  output  1  increment program counter
load_acc  output  1  load accumulator from ALU
load_pc  output  1  load PC from instruction address field
rd  output  1  memory read enable
wr  output  1  memory write enable
load_ir  output  1  load instruction register
datactl_ena  output  1  drive accumulator onto data bus
halt  output  1  processor halted

Behaviour:
- One clock; reset is synchronous and active-high. Ports are named clk and reset. All state changes happen on the rising edge of clk.
- Opcodes: HLT=000, SKZ=001, ADD=010, ANDD=011, XORR=100, LDA=101, STO=110, JMP=111. ALU-class = ADD, ANDD, XORR, LDA.
- States: IDLE, S0..S7, HALTED.
- Reset: state=IDLE, all outputs=0. Reset overrides everything, including in HALTED and mid-cycle.
- IDLE: all outputs 0. Move to S0 on the first edge where fetch=1. After that, fetch is ignored until the next reset.
- Sequence is S0→S1→…→S7→S0, one step per clock. Outputs are registered.
- The output set listed for Sk is loaded at the edge that leaves Sk. It is therefore visible for exactly the one cycle after that edge.
- opcode and zero are sampled at that same edge. Any strobe not listed below is 0.
  - S0: load_ir, rd.
  - S1: inc_pc, load_ir, rd.
  - S2: none.
  - S3: inc_pc. If HLT, also halt.
  - S4: JMP → load_pc. ALU-class → rd. STO → datactl_ena.
  - S5: ALU-class → load_acc, rd. SKZ and zero=1 → inc_pc. JMP → inc_pc, load_pc. STO → wr, datactl_ena.
  - S6: STO → datactl_ena. ALU-class → rd.
  - S7: SKZ and zero=1 → inc_pc.
- HLT with HALT_STICKY=1:
  - The S3 edge moves to HALTED instead of S4.
  - In HALTED, halt=1 and every other output=0 until reset.
  - fetch, opcode and zero are ignored while HALTED.
- HLT with HALT_STICKY=0: halt=1 for one cycle only and the sequence continues normally.
- Mutual exclusion: rd and wr are never 1 in the same cycle. wr=1 implies datactl_ena=1.
- opcode values are all legal, so there is no default branch.
- An illegal state encoding recovers to IDLE on the next edge with outputs 0.
- Latency: the first strobe (load_ir, rd) appears 2 clocks after the edge that samples fetch=1.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams HLT..JMP;
  - the state encoding (IDLE, S0..S7, HALTED, one-hot 10-bit);
  - a 7-bit strobe bundle ordering {inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena}.
- One sub-module, machine_ctl_decode: combinational (state, opcode, zero) → strobe bundle. The top holds the state register, the IDLE/fetch start latch, halt handling and the output registers.

Test Plan:
- Reset mid-S5 of a STO cycle → next cycle: all outputs 0, state IDLE; stays idle until fetch=1.
- reset released, fetch=0 for 10 clocks → all outputs 0; fetch=1 at edge t → load_ir=rd=1 during cycle t+2.
- opcode=STO, zero=x → strobe sequence over S0..S7:
  - rd at S0, S1; inc_pc at S1, S3; load_ir at S0, S1;
  - datactl_ena at S4, S5, S6; wr only at S5;
  - rd never coincides with wr.
- opcode=SKZ, zero=1 → inc_pc after S1, S3, S5 and S7 (4 pulses per cycle). With zero=0 → inc_pc only after S1 and S3.
- opcode=JMP → load_pc after S4 and S5; inc_pc with load_pc after S5.
- opcode=ADD → rd after S0, S1, S4, S5 and S6; load_acc only after S5.
- HLT, HALT_STICKY=1 → halt rises after S3 and stays 1 for 20 clocks with other strobes 0; reset → halt=0, IDLE.
- HLT, HALT_STICKY=0 → halt is a 1-cycle pulse and the next load_ir appears 5 clocks later.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU instruction-sequencing controller: opcodes,
// one-hot machine-cycle states and the datapath strobe bundle.
package cpu_pkg;

  localparam logic [2:0] HLT  = 3'b000;
  localparam logic [2:0] SKZ  = 3'b001;
  localparam logic [2:0] ADD  = 3'b010;
  localparam logic [2:0] ANDD = 3'b011;
  localparam logic [2:0] XORR = 3'b100;
  localparam logic [2:0] LDA  = 3'b101;
  localparam logic [2:0] STO  = 3'b110;
  localparam logic [2:0] JMP  = 3'b111;

  typedef enum logic [9:0] {
    IDLE   = 10'b00_0000_0001,
    S0     = 10'b00_0000_0010,
    S1     = 10'b00_0000_0100,
    S2     = 10'b00_0000_1000,
    S3     = 10'b00_0001_0000,
    S4     = 10'b00_0010_0000,
    S5     = 10'b00_0100_0000,
    S6     = 10'b00_1000_0000,
    S7     = 10'b01_0000_0000,
    HALTED = 10'b10_0000_0000
  } state_t;

  typedef struct packed {
    logic inc_pc;
    logic load_acc;
    logic load_pc;
    logic rd;
    logic wr;
    logic load_ir;
    logic datactl_ena;
  } strobe_t;

  function automatic logic is_alu(input logic [2:0] op);
    return (op == ADD) || (op == ANDD) || (op == XORR) || (op == LDA);
  endfunction

  function automatic state_t next_step(input state_t s);
    case (s)
      S0:      return S1;
      S1:      return S2;
      S2:      return S3;
      S3:      return S4;
      S4:      return S5;
      S5:      return S6;
      S6:      return S7;
      S7:      return S0;
      default: return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/machine_ctl_if.sv
// Controller-side bundle: fetch/opcode/zero in, datapath strobes out.
// slave = the controller, master = whatever drives and observes it.
interface machine_ctl_if;
  logic       fetch;
  logic [2:0] opcode;
  logic       zero;
  logic       inc_pc;
  logic       load_acc;
  logic       load_pc;
  logic       rd;
  logic       wr;
  logic       load_ir;
  logic       datactl_ena;
  logic       halt;

  modport slave (
    input  fetch, opcode, zero,
    output inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt
  );

  modport master (
    output fetch, opcode, zero,
    input  inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt
  );
endinterface

// File: rtl/machine_ctl_decode.sv
// Combinational strobe decode for one machine-cycle step, given the opcode
// and accumulator zero flag. Non-cycle states decode to all-zero.
module machine_ctl_decode
  import cpu_pkg::*;
(
  input  state_t     i_state,
  input  logic [2:0] i_opcode,
  input  logic       i_zero,
  output strobe_t    o_strobe
);

  logic w_alu;
  logic w_skz_taken;

  assign w_alu       = is_alu(i_opcode);
  assign w_skz_taken = (i_opcode == SKZ) && i_zero;

  always_comb begin
    // NOTE: default every output first so no path through the case leaves
    // a strobe unassigned, which would otherwise infer a latch.
    o_strobe = '0;
    case (i_state)
      S0: begin
        o_strobe.load_ir = 1'b1;
        o_strobe.rd      = 1'b1;
      end
      S1: begin
        o_strobe.inc_pc  = 1'b1;
        o_strobe.load_ir = 1'b1;
        o_strobe.rd      = 1'b1;
      end
      S3: o_strobe.inc_pc = 1'b1;
      S4: begin
        o_strobe.load_pc     = (i_opcode == JMP);
        o_strobe.rd          = w_alu;
        o_strobe.datactl_ena = (i_opcode == STO);
      end
      S5: begin
        o_strobe.load_acc    = w_alu;
        o_strobe.rd          = w_alu;
        o_strobe.inc_pc      = w_skz_taken || (i_opcode == JMP);
        o_strobe.load_pc     = (i_opcode == JMP);
        o_strobe.wr          = (i_opcode == STO);
        o_strobe.datactl_ena = (i_opcode == STO);
      end
      S6: begin
        o_strobe.datactl_ena = (i_opcode == STO);
        o_strobe.rd          = w_alu;
      end
      S7: o_strobe.inc_pc = w_skz_taken;
      default: o_strobe = '0;
    endcase
  end

endmodule

// File: rtl/machine_ctl.sv
// Instruction-sequencing controller: idles until the first fetch, then runs
// a free-running 8-step machine cycle with registered datapath strobes.
module machine_ctl
  import cpu_pkg::*;
#(
  parameter bit HALT_STICKY = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  machine_ctl_if.slave  bus
);

  state_t  r_state;
  strobe_t r_strobe;
  logic    r_halt;
  strobe_t w_strobe;

  machine_ctl_decode u_decode (
    .i_state  (r_state),
    .i_opcode (bus.opcode),
    .i_zero   (bus.zero),
    .o_strobe (w_strobe)
  );

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge
    // values, independent of statement order.
    if (reset) begin
      r_state  <= IDLE;
      r_strobe <= '0;
      r_halt   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_strobe <= '0;
          r_halt   <= 1'b0;
          if (bus.fetch) r_state <= S0;
        end
        S0, S1, S2, S4, S5, S6, S7: begin
          r_strobe <= w_strobe;
          r_halt   <= 1'b0;
          r_state  <= next_step(r_state);
        end
        S3: begin
          // A sticky halt shows only halt from the first HALTED cycle on.
          if (HALT_STICKY && (bus.opcode == HLT)) begin
            r_strobe <= '0;
            r_halt   <= 1'b1;
            r_state  <= HALTED;
          end else begin
            r_strobe <= w_strobe;
            r_halt   <= (bus.opcode == HLT);
            r_state  <= S4;
          end
        end
        HALTED: begin
          r_strobe <= '0;
          r_halt   <= 1'b1;
        end
        default: begin
          r_state  <= IDLE;
          r_strobe <= '0;
          r_halt   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.inc_pc      = r_strobe.inc_pc;
  assign bus.load_acc    = r_strobe.load_acc;
  assign bus.load_pc     = r_strobe.load_pc;
  assign bus.rd          = r_strobe.rd;
  assign bus.wr          = r_strobe.wr;
  assign bus.load_ir     = r_strobe.load_ir;
  assign bus.datactl_ena = r_strobe.datactl_ena;
  assign bus.halt        = r_halt;

endmodule

// File: tb/tb_machine_ctl.sv
// Self-checking bench for machine_ctl: sticky and non-sticky instances share
// stimulus and are compared every cycle against a step-counting reference.
module tb_machine_ctl;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fetch = 1'b0;
  logic [2:0] opcode = 3'b000;
  logic       zero = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state per instance: [0] sticky, [1] non-sticky. phase -1 = idle.
  int         m_phase  [2];
  bit         m_halted [2];
  logic [7:0] m_exp    [2];

  always #5 clk = ~clk;

  machine_ctl_if if_s ();
  machine_ctl_if if_n ();

  assign if_s.fetch  = fetch;
  assign if_s.opcode = opcode;
  assign if_s.zero   = zero;
  assign if_n.fetch  = fetch;
  assign if_n.opcode = opcode;
  assign if_n.zero   = zero;

  machine_ctl #(.HALT_STICKY(1'b1)) u_dut_s (.clk(clk), .reset(reset), .bus(if_s.slave));
  machine_ctl #(.HALT_STICKY(1'b0)) u_dut_n (.clk(clk), .reset(reset), .bus(if_n.slave));

  // {halt, inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena}
  wire [7:0] obs_s = {if_s.halt, if_s.inc_pc, if_s.load_acc, if_s.load_pc,
                      if_s.rd, if_s.wr, if_s.load_ir, if_s.datactl_ena};
  wire [7:0] obs_n = {if_n.halt, if_n.inc_pc, if_n.load_acc, if_n.load_pc,
                      if_n.rd, if_n.wr, if_n.load_ir, if_n.datactl_ena};

  // Strobes produced when leaving step s, written as per-strobe rules.
  function automatic logic [7:0] strobes(input int s, input logic [2:0] op, input logic z);
    logic alu, sto, jmp, skz_t;
    alu   = (op == ADD) || (op == ANDD) || (op == XORR) || (op == LDA);
    sto   = (op == STO);
    jmp   = (op == JMP);
    skz_t = (op == SKZ) && z;
    return {
      (s == 3) && (op == HLT),
      (s == 1) || (s == 3) || (skz_t && (s == 5 || s == 7)) || (jmp && s == 5),
      alu && (s == 5),
      jmp && (s == 4 || s == 5),
      (s <= 1) || (alu && s >= 4 && s <= 6),
      sto && (s == 5),
      (s <= 1),
      sto && s >= 4 && s <= 6
    };
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_phase[k] = -1; m_halted[k] = 1'b0; m_exp[k] = 8'h00;
      end else if (m_halted[k]) begin
        m_exp[k] = 8'h80;
      end else if (m_phase[k] < 0) begin
        m_exp[k] = 8'h00;
        if (fetch) m_phase[k] = 0;
      end else if (k == 0 && m_phase[k] == 3 && opcode == HLT) begin
        m_halted[k] = 1'b1; m_exp[k] = 8'h80;
      end else begin
        m_exp[k]   = strobes(m_phase[k], opcode, zero);
        m_phase[k] = (m_phase[k] + 1) % 8;
      end
    end
  endtask

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("outs_sticky", obs_s, m_exp[0]);
    check("outs_nonsticky", obs_n, m_exp[1]);
    check("excl_sticky", {6'b0, if_s.rd & if_s.wr, if_s.wr & ~if_s.datactl_ena}, 8'h00);
    check("excl_nonsticky", {6'b0, if_n.rd & if_n.wr, if_n.wr & ~if_n.datactl_ena}, 8'h00);
  endtask

  // Hold one opcode for n steps; zero is fixed or random, fetch is noise.
  task automatic run_cycle(input logic [2:0] op, input int zmode, input int n);
    for (int i = 0; i < n; i++) begin
      opcode = op;
      zero   = (zmode == 2) ? 1'($urandom) : 1'(zmode);
      fetch  = 1'($urandom);
      tick();
    end
  endtask

  task automatic idle_then_start();
    fetch = 1'b0;
    for (int i = 0; i < 10; i++) begin
      opcode = 3'($urandom);
      zero   = 1'($urandom);
      tick();
    end
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
  endtask

  initial begin
    m_phase  = '{-1, -1};
    m_halted = '{1'b0, 1'b0};
    m_exp    = '{8'h00, 8'h00};

    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    idle_then_start();

    run_cycle(STO, 2, 8);
    run_cycle(SKZ, 1, 8);
    run_cycle(SKZ, 0, 8);
    run_cycle(JMP, 2, 8);
    run_cycle(ADD, 2, 8);
    run_cycle(ANDD, 2, 8);
    run_cycle(XORR, 2, 8);
    run_cycle(LDA, 2, 8);

    for (int c = 0; c < 16; c++)
      run_cycle(3'($urandom_range(1, 7)), 2, 8);

    // Reset while a STO cycle sits in S5.
    run_cycle(STO, 2, 5);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    idle_then_start();

    // HLT: sticky instance parks, non-sticky pulses halt and carries on.
    run_cycle(HLT, 2, 8);
    run_cycle(ADD, 2, 8);
    for (int i = 0; i < 20; i++)
      run_cycle(3'($urandom), 2, 1);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    fetch = 1'b0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
